// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the data_memory block.
// The optional DATA_MEMORY_ERR_EN build adds address error reporting.
package dmem_pkg;

    localparam int WORD_W      = 32;
    localparam int BYTE_OFS_W  = 2;
    localparam logic [WORD_W-1:0] RESET_FILL = 32'h0;

    function automatic int dmem_idx_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/dmem_addr_decode.sv
// Byte address to word index decode. With DATA_MEMORY_ERR_EN it also flags
// misaligned and out-of-range addresses.
module dmem_addr_decode
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 8
) (
    input  logic [ADDR_W-1:0] address,
`ifdef DATA_MEMORY_ERR_EN
    output logic              misaligned,
    output logic              out_of_range,
`endif
    output logic [IDX_W-1:0]  index
);

    assign index = address[IDX_W+BYTE_OFS_W-1:BYTE_OFS_W];

`ifdef DATA_MEMORY_ERR_EN
    assign misaligned   = |address[BYTE_OFS_W-1:0];
    assign out_of_range = |address[ADDR_W-1:IDX_W+BYTE_OFS_W];
`else
    // Offset and high bits are dropped: accesses align and wrap silently.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{address[BYTE_OFS_W-1:0], address[ADDR_W-1:IDX_W+BYTE_OFS_W]};
`endif

endmodule

// File: rtl/data_memory.sv
// Word-organised data RAM: synchronous write, combinational read, async clear.
// Define DATA_MEMORY_ERR_EN to add the err output and suppress bad accesses.
module data_memory
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = WORD_W,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    input  logic              mem_read,
    input  logic              mem_write,
`ifdef DATA_MEMORY_ERR_EN
    output logic              err,
`endif
    output logic [DATA_W-1:0] read_data
);

    localparam int IDX_W = dmem_idx_w(DEPTH);

    logic [IDX_W-1:0]  index;
    logic              access_err;
    logic              wr_en;
    logic [DATA_W-1:0] mem_q [DEPTH];

`ifdef DATA_MEMORY_ERR_EN
    logic misaligned;
    logic out_of_range;

    dmem_addr_decode #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) u_addr_decode (
        .address      (address),
        .misaligned   (misaligned),
        .out_of_range (out_of_range),
        .index        (index)
    );

    assign access_err = rst_n & (mem_read | mem_write) & (misaligned | out_of_range);
    assign err        = access_err;
`else
    dmem_addr_decode #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) u_addr_decode (
        .address (address),
        .index   (index)
    );

    assign access_err = 1'b0;
`endif

    // Only an explicit 1 on mem_write writes; X/Z evaluates false here.
    assign wr_en = (mem_write == 1'b1) && !access_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_FILL;
            end
        end else if (wr_en) begin
            mem_q[index] <= write_data;
        end
    end

    assign read_data = (mem_read && !access_err) ? mem_q[index] : '0;

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory (default build, and the
// DATA_MEMORY_ERR_EN build when that macro is defined).
module tb_data_memory;

    logic        clk;
    logic        rst_n;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] read_data;
`ifdef DATA_MEMORY_ERR_EN
    logic        err;
`endif

    int n_vec;
    int n_err;

    data_memory #(.ADDR_W(32), .DATA_W(32), .DEPTH(256)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .address    (address),
        .write_data (write_data),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
`ifdef DATA_MEMORY_ERR_EN
        .err        (err),
`endif
        .read_data  (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        write_data = d;
        mem_write  = 1'b1;
        mem_read   = 1'b0;
        @(posedge clk);
        #1;
        mem_write  = 1'b0;
    endtask

    task automatic test_reset;
        do_write(32'h8, 32'hDEADBEEF);
        @(negedge clk);
        address  = 32'h8;
        mem_read = 1'b1;
        #1;
        n_vec++;
        if (read_data !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL reset_prewrite: got %h want %h", read_data, 32'hDEADBEEF);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (read_data !== 32'h0) begin
            n_err++;
            $display("FAIL reset_async_clear: got %h want %h", read_data, 32'h0);
        end
        write_data = 32'hFFFFFFFF;
        mem_write  = 1'b1;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (read_data !== 32'h0) begin
            n_err++;
            $display("FAIL reset_after_release: got %h want %h", read_data, 32'h0);
        end
    endtask

    task automatic test_write_read;
        do_write(32'h4, 32'h12345678);
        @(negedge clk);
        address  = 32'h4;
        mem_read = 1'b1;
        #1;
        n_vec++;
        if (read_data !== 32'h12345678) begin
            n_err++;
            $display("FAIL write_read_0x4: got %h want %h", read_data, 32'h12345678);
        end
        do_write(32'hC, 32'hCAFEF00D);
        @(negedge clk);
        address  = 32'h4;
        mem_read = 1'b1;
        #1;
        n_vec++;
        if (read_data !== 32'h12345678) begin
            n_err++;
            $display("FAIL write_neighbour_intact: got %h want %h", read_data, 32'h12345678);
        end
        address = 32'hC;
        #1;
        n_vec++;
        if (read_data !== 32'hCAFEF00D) begin
            n_err++;
            $display("FAIL write_read_0xC: got %h want %h", read_data, 32'hCAFEF00D);
        end
    endtask

    task automatic test_read_gating;
        @(negedge clk);
        address  = 32'h4;
        mem_read = 1'b0;
        #1;
        n_vec++;
        if (read_data !== 32'h0) begin
            n_err++;
            $display("FAIL read_gated_off: got %h want %h", read_data, 32'h0);
        end
        mem_read = 1'b1;
        #1;
        n_vec++;
        if (read_data !== 32'h12345678) begin
            n_err++;
            $display("FAIL read_gated_on: got %h want %h", read_data, 32'h12345678);
        end
    endtask

    task automatic test_hold;
        @(negedge clk);
        address    = 32'hC;
        write_data = 32'h55555555;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if (read_data !== 32'h0) begin
            n_err++;
            $display("FAIL hold_idle_read: got %h want %h", read_data, 32'h0);
        end
        mem_read = 1'b1;
        #1;
        n_vec++;
        if (read_data !== 32'hCAFEF00D) begin
            n_err++;
            $display("FAIL hold_contents: got %h want %h", read_data, 32'hCAFEF00D);
        end
    endtask

`ifndef DATA_MEMORY_ERR_EN
    task automatic test_align_wrap;
        do_write(32'h6, 32'hA5A5A5A5);
        @(negedge clk);
        mem_read = 1'b1;
        address  = 32'h4;
        #1;
        n_vec++;
        if (read_data !== 32'hA5A5A5A5) begin
            n_err++;
            $display("FAIL align_read_0x4: got %h want %h", read_data, 32'hA5A5A5A5);
        end
        address = 32'h404;
        #1;
        n_vec++;
        if (read_data !== 32'hA5A5A5A5) begin
            n_err++;
            $display("FAIL wrap_read_0x404: got %h want %h", read_data, 32'hA5A5A5A5);
        end
        do_write(32'h8000_0400, 32'h0F0F0F0F);
        @(negedge clk);
        mem_read = 1'b1;
        address  = 32'h0;
        #1;
        n_vec++;
        if (read_data !== 32'h0F0F0F0F) begin
            n_err++;
            $display("FAIL wrap_write_to_0x0: got %h want %h", read_data, 32'h0F0F0F0F);
        end
    endtask
`endif

    task automatic test_same_cycle;
        do_write(32'h10, 32'h11111111);
        @(negedge clk);
        address    = 32'h10;
        write_data = 32'h22222222;
        mem_read   = 1'b1;
        mem_write  = 1'b1;
        #1;
        n_vec++;
        if (read_data !== 32'h11111111) begin
            n_err++;
            $display("FAIL rw_before_edge: got %h want %h", read_data, 32'h11111111);
        end
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        n_vec++;
        if (read_data !== 32'h22222222) begin
            n_err++;
            $display("FAIL rw_after_edge: got %h want %h", read_data, 32'h22222222);
        end
    endtask

`ifdef DATA_MEMORY_ERR_EN
    task automatic test_err;
        do_write(32'h0, 32'h0BADF00D);
        @(negedge clk);
        address    = 32'h2;
        write_data = 32'h77777777;
        mem_write  = 1'b1;
        #1;
        n_vec++;
        if (err !== 1'b1) begin
            n_err++;
            $display("FAIL err_misaligned_write: got %b want %b", err, 1'b1);
        end
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        mem_read  = 1'b1;
        address   = 32'h0;
        #1;
        n_vec++;
        if (read_data !== 32'h0BADF00D) begin
            n_err++;
            $display("FAIL err_write_suppressed: got %h want %h", read_data, 32'h0BADF00D);
        end
        address = 32'h400;
        #1;
        n_vec++;
        if (err !== 1'b1 || read_data !== 32'h0) begin
            n_err++;
            $display("FAIL err_out_of_range_read: got err=%b data=%h want err=1 data=0", err, read_data);
        end
        do_write(32'h3FC, 32'h3C3C3C3C);
        @(negedge clk);
        address  = 32'h3FC;
        mem_read = 1'b1;
        #1;
        n_vec++;
        if (err !== 1'b0 || read_data !== 32'h3C3C3C3C) begin
            n_err++;
            $display("FAIL err_top_word_ok: got err=%b data=%h want err=0 data=3c3c3c3c", err, read_data);
        end
    endtask
`endif

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        address    = '0;
        write_data = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        test_reset;
        test_write_read;
        test_read_gating;
        test_hold;
`ifndef DATA_MEMORY_ERR_EN
        test_align_wrap;
`endif
        test_same_cycle;
`ifdef DATA_MEMORY_ERR_EN
        test_err;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
